serial_tx_fifo: RTL and testbench

//   Byte FIFO between the SoC transmit port (tx_valid/tx_ready/tx_data) and the

---
 rtl/serial_tx_fifo.sv | 68 ++++++
 tb/tb_serial_tx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: first-word-fall-through byte FIFO between the SoC transmit port and the serial line.
// Optional SERIAL_TX_FIFO_CRLF_EN expands a head byte 8'h0A into the beats 8'h0D, 8'h0A (WIDTH must be 8).
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    head_q, head_d;
    logic                full, empty, push, pop;
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign level     = wr_ptr_q - rd_ptr_q;
`ifdef SERIAL_TX_FIFO_CRLF_EN
    logic cr_q, cr_d, lf_head;
    assign lf_head  = head_q == 8'h0A;
    assign pop      = out_valid && out_ready && (!lf_head || cr_q);
    assign out_data = (out_valid && lf_head && !cr_q) ? 8'h0D : head_q;
    always_comb begin
        cr_d = pop ? 1'b0 : (out_valid && out_ready && lf_head) ? 1'b1 : cr_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cr_q <= 1'b0;
        else          cr_q <= cr_d;
    end
`else
    assign pop      = out_valid && out_ready;
    assign out_data = head_q;
`endif
    // head_q is the registered FIFO head; a push into a slot that becomes the head bypasses the array
    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (pop ? 1'b1 : 1'b0);
        head_d   = head_q;
        if (rd_ptr_d != wr_ptr_d)
            head_d = (push && rd_ptr_d[DEPTH_LOG2-1:0] == wr_ptr_q[DEPTH_LOG2-1:0])
                     ? in_data : mem[rd_ptr_d[DEPTH_LOG2-1:0]];
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed bench for serial_tx_fifo (16 x 8), honouring SERIAL_TX_FIFO_CRLF_EN when defined.
module tb_serial_tx_fifo;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] level;
    int total = 0;
    int bad = 0;

    serial_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 5'd0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: in_ready=%b out_valid=%b level=%0d, want 1 0 0", i, in_ready, out_valid, level);
            end
        end
        total++;
        if (out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: out_data=%h want 00", out_data);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'h41; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h41 || level !== 5'd1) begin
                bad++;
                $display("FAIL single_hold[%0d]: out_valid=%b out_data=%h level=%0d, want 1 41 1", i, out_valid, out_data, level);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0 || out_data !== 8'h41) begin
            bad++;
            $display("FAIL single_pop: out_valid=%b level=%0d out_data=%h, want 0 0 41", out_valid, level, out_data);
        end
    endtask

    task automatic test_full();
        logic [7:0] exp [$];
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        total++;
        if (level !== 5'd16 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_level: level=%0d in_ready=%b, want 16 0", level, in_ready);
        end
        in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        total++;
        if (level !== 5'd16 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_reject: level=%0d in_ready=%b, want 16 0", level, in_ready);
        end
        for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_TX_FIFO_CRLF_EN
            if (i == 10) exp.push_back(8'h0D);
`endif
            exp.push_back(8'(i));
        end
        foreach (exp[k]) begin
            out_ready = 1'b1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[k]) begin
                bad++;
                $display("FAIL full_drain[%0d]: out_valid=%b out_data=%h, want 1 %h", k, out_valid, out_data, exp[k]);
            end
            if (k == 0) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL full_same_cycle: in_ready=%b want 0", in_ready);
                end
            end
            tick();
            if (k == 0) begin
                total++;
                if (in_ready !== 1'b1 || level !== 5'd15) begin
                    bad++;
                    $display("FAIL full_first_pop: in_ready=%b level=%0d, want 1 15", in_ready, level);
                end
            end
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            bad++;
            $display("FAIL full_empty: out_valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h80 + 8'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_data = 8'h83 + 8'(c);
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h80 + 8'(c) || level !== 5'd3 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d]: out_valid=%b out_data=%h level=%0d in_ready=%b, want 1 %h 3 1",
                         c, out_valid, out_data, level, in_ready, 8'h80 + 8'(c));
            end
            tick();
        end
        in_valid = 1'b0;
        for (int c = 100; c < 103; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h80 + 8'(c)) begin
                bad++;
                $display("FAIL b2b_tail[%0d]: out_valid=%b out_data=%h, want 1 %h", c, out_valid, out_data, 8'h80 + 8'(c));
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            bad++;
            $display("FAIL b2b_empty: out_valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'h30 + 8'(i);
            tick();
        end
        in_data = 8'h99;
        total++;
        if (level !== 5'd7) begin
            bad++;
            $display("FAIL arst_pre: level=%0d want 7", level);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL arst_async: out_valid=%b level=%0d in_ready=%b, want 0 0 1", out_valid, level, in_ready);
        end
        tick();
        tick();
        in_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || level !== 5'd0) begin
                bad++;
                $display("FAIL arst_after[%0d]: out_valid=%b level=%0d, want 0 0", i, out_valid, level);
            end
        end
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || level !== 5'd1) begin
            bad++;
            $display("FAIL arst_fresh: out_valid=%b out_data=%h level=%0d, want 1 55 1", out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            bad++;
            $display("FAIL arst_drain: out_valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    task automatic test_crlf();
        logic [7:0] exp_d [$];
        logic [4:0] exp_l [$];
        in_valid = 1'b1; in_data = 8'h61; tick();
        in_data = 8'h0A; tick();
        in_data = 8'h62; tick();
        in_valid = 1'b0;
`ifdef SERIAL_TX_FIFO_CRLF_EN
        exp_d = '{8'h61, 8'h0D, 8'h0A, 8'h62};
        exp_l = '{5'd3, 5'd2, 5'd2, 5'd1};
`else
        exp_d = '{8'h61, 8'h0A, 8'h62};
        exp_l = '{5'd3, 5'd2, 5'd1};
`endif
        foreach (exp_d[k]) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || level !== exp_l[k]) begin
                bad++;
                $display("FAIL crlf_beat[%0d]: out_valid=%b out_data=%h level=%0d, want 1 %h %0d",
                         k, out_valid, out_data, level, exp_d[k], exp_l[k]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        total++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            bad++;
            $display("FAIL crlf_empty: out_valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_async_reset();
        test_crlf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
